div_iter_unit: RTL
==================

Name: div_iter_unit

Overview:
Parametrised iterative integer divider for the M-extension execute stage, the next generation of the single-mode divider. Retires BITS_PER_CYCLE quotient bits per cycle. Implements full RISC-V DIV/DIVU/REM/REMU semantics, including divide-by-zero and signed overflow. Uses valid/ready handshakes on both sides, plus pipeline stall and flush.

Parameters:
WIDTH, 32, operand/result width; even, >= 4.
BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle; one of 1, 2, 4; must divide WIDTH.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  asynchronous active-low reset.
STALL  in  1  freezes all state and outputs while high; FLUSH still acts.
FLUSH  in  1  synchronous abort; returns to IDLE next edge, result discarded.
IN_VALID  in  1  request valid.
IN_READY  out  1  unit can accept a request.
SIGN  in  1  1 = signed (DIV/REM), 0 = unsigned.
DIVIDEND  in  WIDTH  dividend.
DIVISOR  in  WIDTH  divisor.
OUT_VALID  out  1  QUOTIENT/REMAINDER valid.
OUT_READY  in  1  consumer accepts result.
QUOTIENT  out  WIDTH  registered quotient.
REMAINDER  out  WIDTH  registered remainder.
BUSY  out  1  state != IDLE.

Behaviour:
- Reset (RST_N low, async): state IDLE, OUT_VALID=0, QUOTIENT=0, REMAINDER=0, iteration counter 0, BUSY=0, IN_READY=1 once RST_N is high.
- States: IDLE, CALC, FIX, DONE.
- IN_READY = (state==IDLE) && !STALL.
- Accept: edge with IN_VALID && IN_READY. All inputs are latched here; nothing later depends on live inputs.
- On accept: latch SIGN, sign(DIVIDEND), sign(DIVISOR), |DIVIDEND|, |DIVISOR| (magnitudes only when SIGN=1). Set quot_neg = SIGN && (sd ^ sv), rem_neg = SIGN && sd.
- Special cases, detected at accept; state goes straight to FIX:
  - DIVISOR==0 -> Q = all ones, R = DIVIDEND.
  - SIGN && DIVIDEND==100..0 && DIVISOR==all ones -> Q = DIVIDEND, R = 0.
- Normal case: state to CALC, counter = WIDTH/BITS_PER_CYCLE.
- CALC, each non-stalled cycle:
  - Perform BITS_PER_CYCLE chained restoring steps on partial remainder (WIDTH+1 bits) and shifting quotient.
  - Decrement counter; when it reaches 0 -> FIX.
- FIX (1 cycle): Q = quot_neg ? -q : q; R = rem_neg ? -r : r, in two's complement, modulo 2^WIDTH. Register into QUOTIENT/REMAINDER, set OUT_VALID=1, go to DONE.
- DONE: hold outputs stable until OUT_READY && !STALL. At that edge, OUT_VALID=0 and state returns to IDLE. No new accept in the same edge.
- Latency, accept edge to OUT_VALID high:
  - Normal: WIDTH/BITS_PER_CYCLE + 1 edges (33 for 32/1; 9 for 32/4).
  - Special case: 1 edge.
- STALL high: no state, counter, datapath or output change; OUT_VALID holds its value.
- FLUSH high, any state: next edge gives IDLE, OUT_VALID=0. FLUSH overrides STALL and a simultaneous accept; the request is dropped.
- Reset mid-operation: immediate return to reset values; no partial result is ever presented.
- QUOTIENT/REMAINDER keep the last delivered values after handshake, until the next FIX.
- Identities that must hold for every valid request:
  - Signed: DIVIDEND = Q*DIVISOR + R with |R| < |DIVISOR| and sign(R) = sign(DIVIDEND).
  - Unsigned: 0 <= R < DIVISOR.

Decomposition:
- Package div_pkg holds:
  - state enum (IDLE/CALC/FIX/DONE);
  - function for two's-complement negate/abs;
  - localparam ITER = WIDTH/BITS_PER_CYCLE;
  - counter width $clog2(ITER)+1.
- Sub-module div_step:
  - purely combinational single radix-2 restoring step (partial remainder, divisor, quotient in -> out);
  - instantiated BITS_PER_CYCLE times via generate.
  - Top holds FSM, latches and fix-up.

Test Plan:
1. Unsigned, BITS_PER_CYCLE=1: 100/7 -> Q=14, R=2; OUT_VALID exactly 33 edges after accept.
2. Signed: -7/2 (0xFFFFFFF9/0x2) -> Q=0xFFFFFFFD, R=0xFFFFFFFF; 7/-2 -> Q=0xFFFFFFFD, R=1.
3. Divide by zero: SIGN=1, 5/0 -> Q=0xFFFFFFFF, R=5. Overflow: 0x80000000/0xFFFFFFFF signed -> Q=0x80000000, R=0. Both cases give OUT_VALID 1 edge after accept.
4. BITS_PER_CYCLE=4: 0xFFFFFFFF/0x10 unsigned -> Q=0x0FFFFFFF, R=0xF; latency 9 edges. Plus 10k random vectors checked against reference model for all parameter sets.
5. Handshake: hold OUT_READY low 5 cycles -> outputs stable, IN_READY=0. STALL for 3 cycles inside CALC -> latency grows by exactly 3, result unchanged.
6. FLUSH at CALC cycle 10, and RST_N pulse mid-CALC -> IDLE next edge / immediately, OUT_VALID never asserted. Subsequent 100/7 still gives 14 r 2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative divider: FSM states, iteration
// sizing and a wide two's-complement negate used by the sign fix-up.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_e;

  localparam int MAX_W     = 64;
  localparam int WIDTH_DEF = 32;
  localparam int BPC_DEF   = 1;
  localparam int ITER      = WIDTH_DEF / BPC_DEF;
  localparam int CNT_W     = $clog2(ITER) + 1;

  typedef logic [MAX_W-1:0] word_t;

  function automatic int iter_count(input int width, input int bpc);
    return width / bpc;
  endfunction

  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(width / bpc) + 1;
  endfunction

  function automatic word_t twos_neg(input word_t x);
    return ~x + word_t'(1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, shift in the quotient bit.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   part_rem,
  input  logic [WIDTH-1:0] quot,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   next_rem,
  output logic [WIDTH-1:0] next_quot
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             borrow;

  // One extra guard bit so the borrow of the trial subtraction is always visible.
  assign shifted   = {part_rem, quot[WIDTH-1]};
  assign diff      = shifted - {2'b00, divisor};
  assign borrow    = diff[WIDTH+1];
  assign next_rem  = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
  assign next_quot = {quot[WIDTH-2:0], ~borrow};

endmodule

// File: rtl/div_iter_unit.sv
// Iterative RISC-V DIV/DIVU/REM/REMU unit: magnitudes are divided with a chain of
// restoring steps per cycle, then signs are restored in a single fix-up cycle.
module div_iter_unit
  import div_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             STALL,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             SIGN,
  input  logic [WIDTH-1:0] DIVIDEND,
  input  logic [WIDTH-1:0] DIVISOR,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             BUSY
);

  localparam int N_ITER = iter_count(WIDTH, BITS_PER_CYCLE);
  localparam int N_CNTW = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return WIDTH'(twos_neg(word_t'(x)));
  endfunction

  div_state_e        state;
  logic [N_CNTW-1:0] cnt;
  logic [WIDTH:0]    rem_q;
  logic [WIDTH-1:0]  quot_q;
  logic [WIDTH-1:0]  div_q;
  logic              quot_neg;
  logic              rem_neg;

  logic              dvd_neg;
  logic              dvs_neg;
  logic [WIDTH-1:0]  dvd_mag;
  logic [WIDTH-1:0]  dvs_mag;
  logic              is_zero;
  logic              is_ovf;
  logic              take;

  assign IN_READY = (state == IDLE) && !STALL;
  assign BUSY     = (state != IDLE);
  assign take     = (state == IDLE) && IN_VALID;

  assign dvd_neg = SIGN && DIVIDEND[WIDTH-1];
  assign dvs_neg = SIGN && DIVISOR[WIDTH-1];
  assign dvd_mag = dvd_neg ? negate(DIVIDEND) : DIVIDEND;
  assign dvs_mag = dvs_neg ? negate(DIVISOR) : DIVISOR;
  assign is_zero = (DIVISOR == '0);
  assign is_ovf  = SIGN && (DIVIDEND == MIN_NEG) && (DIVISOR == '1);

  logic [WIDTH:0]   rem_chain  [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] quot_chain [BITS_PER_CYCLE+1];

  assign rem_chain[0]  = rem_q;
  assign quot_chain[0] = quot_q;

  for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
    div_step #(.WIDTH(WIDTH)) u_step (
      .part_rem  (rem_chain[i]),
      .quot      (quot_chain[i]),
      .divisor   (div_q),
      .next_rem  (rem_chain[i+1]),
      .next_quot (quot_chain[i+1])
    );
  end

  // Datapath: operand latch at accept, iterate in CALC. Special cases preload
  // the final answer with the sign flags cleared so FIX passes it through.
  always_ff @(posedge CLK) begin
    if (!STALL) begin
      if (take) begin
        div_q <= dvs_mag;
        if (is_zero) begin
          quot_q   <= '1;
          rem_q    <= {1'b0, DIVIDEND};
          quot_neg <= 1'b0;
          rem_neg  <= 1'b0;
        end else if (is_ovf) begin
          quot_q   <= DIVIDEND;
          rem_q    <= '0;
          quot_neg <= 1'b0;
          rem_neg  <= 1'b0;
        end else begin
          quot_q   <= dvd_mag;
          rem_q    <= '0;
          quot_neg <= dvd_neg ^ dvs_neg;
          rem_neg  <= dvd_neg;
        end
      end else if (state == CALC) begin
        rem_q  <= rem_chain[BITS_PER_CYCLE];
        quot_q <= quot_chain[BITS_PER_CYCLE];
      end
    end
  end

  // Control FSM and registered results; FLUSH wins over STALL and accept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      cnt       <= '0;
      OUT_VALID <= 1'b0;
      QUOTIENT  <= '0;
      REMAINDER <= '0;
    end else if (FLUSH) begin
      state     <= IDLE;
      cnt       <= '0;
      OUT_VALID <= 1'b0;
    end else if (!STALL) begin
      case (state)
        IDLE: begin
          if (IN_VALID) begin
            if (is_zero || is_ovf) begin
              state <= FIX;
              cnt   <= '0;
            end else begin
              state <= CALC;
              cnt   <= N_CNTW'(N_ITER);
            end
          end
        end
        CALC: begin
          cnt <= cnt - N_CNTW'(1);
          if (cnt == N_CNTW'(1)) state <= FIX;
        end
        FIX: begin
          QUOTIENT  <= quot_neg ? negate(quot_q) : quot_q;
          REMAINDER <= rem_neg ? negate(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
          OUT_VALID <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
